// File: rtl/arm_mc_decoder.sv
// Multicycle ARM control unit: Moore FSM plus main, ALU and PC-logic decoders.
// Latency: LDR 5 cycles, STR 4, data-processing 4, B 3; outputs follow State combinationally.
// Backpressure: none; the FSM advances every cycle and UNKNOWN holds until reset.
module arm_mc_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       PCS,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic [1:0] FlagW,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       InstrDone,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_UNKNOWN = 4'd10
    } state_t;

    // Operand-B select encodings.
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result-mux select encodings.
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // ALU operation encodings.
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    state_t state_q;

    // Moore control bundle decoded from the current state.
    logic       irwrite_c;
    logic       nextpc_c;
    logic       regw_c;
    logic       memw_c;
    logic       branch_c;
    logic       aluop_c;
    logic       done_c;
    logic       adrsrc_c;
    logic       alusrca_c;
    logic [1:0] alusrcb_c;
    logic [1:0] resultsrc_c;

    // ALU decoder results.
    logic [1:0] alu_ctl;
    logic [1:0] flag_w;
    logic       alu_known;

    // State register and next-state logic; Op/Funct are only consulted in DECODE and MEMADR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        2'b00:   state_q <= Funct[5] ? S_EXECI : S_EXECR;
                        2'b01:   state_q <= S_MEMADR;
                        2'b10:   state_q <= S_BRANCH;
                        default: state_q <= S_UNKNOWN;
                    endcase
                end
                S_MEMADR:  state_q <= Funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:   state_q <= S_MEMWB;
                S_MEMWB:   state_q <= S_FETCH;
                S_MEMWR:   state_q <= S_FETCH;
                S_EXECR:   state_q <= S_ALUWB;
                S_EXECI:   state_q <= S_ALUWB;
                S_ALUWB:   state_q <= S_FETCH;
                S_BRANCH:  state_q <= S_FETCH;
                S_UNKNOWN: state_q <= S_UNKNOWN;
                default:   state_q <= S_UNKNOWN;
            endcase
        end
    end

    // Main decoder: per-state enables and mux selects; reset forces enables off and FETCH selects.
    always_comb begin
        irwrite_c   = 1'b0;
        nextpc_c    = 1'b0;
        regw_c      = 1'b0;
        memw_c      = 1'b0;
        branch_c    = 1'b0;
        aluop_c     = 1'b0;
        done_c      = 1'b0;
        adrsrc_c    = 1'b0;
        alusrca_c   = 1'b0;
        alusrcb_c   = SRCB_RD2;
        resultsrc_c = RES_ALUOUT;

        case (state_q)
            S_FETCH: begin
                alusrca_c   = 1'b1;
                alusrcb_c   = SRCB_FOUR;
                resultsrc_c = RES_ALU;
                irwrite_c   = 1'b1;
                nextpc_c    = 1'b1;
            end
            S_DECODE: begin
                alusrca_c   = 1'b1;
                alusrcb_c   = SRCB_FOUR;
                resultsrc_c = RES_ALU;
            end
            S_MEMADR: begin
                alusrcb_c = SRCB_IMM;
            end
            S_MEMRD: begin
                adrsrc_c    = 1'b1;
                resultsrc_c = RES_ALUOUT;
            end
            S_MEMWB: begin
                resultsrc_c = RES_DATA;
                regw_c      = 1'b1;
                done_c      = 1'b1;
            end
            S_MEMWR: begin
                adrsrc_c = 1'b1;
                memw_c   = 1'b1;
                done_c   = 1'b1;
            end
            S_EXECR: begin
                alusrcb_c = SRCB_RD2;
                aluop_c   = 1'b1;
            end
            S_EXECI: begin
                alusrcb_c = SRCB_IMM;
                aluop_c   = 1'b1;
            end
            S_ALUWB: begin
                resultsrc_c = RES_ALUOUT;
                regw_c      = 1'b1;
                done_c      = 1'b1;
            end
            S_BRANCH: begin
                alusrcb_c   = SRCB_IMM;
                resultsrc_c = RES_ALU;
                branch_c    = 1'b1;
                done_c      = 1'b1;
            end
            default: begin
                // UNKNOWN (and any illegal encoding): everything stays off.
            end
        endcase

        // An instruction in flight is abandoned: nothing may be written during reset.
        if (reset) begin
            irwrite_c   = 1'b0;
            nextpc_c    = 1'b0;
            regw_c      = 1'b0;
            memw_c      = 1'b0;
            branch_c    = 1'b0;
            aluop_c     = 1'b0;
            done_c      = 1'b0;
            adrsrc_c    = 1'b0;
            alusrca_c   = 1'b1;
            alusrcb_c   = SRCB_FOUR;
            resultsrc_c = RES_ALU;
        end
    end

    // ALU decoder: operation from Funct[4:1]; unsupported opcodes fall back to ADD with no flag update.
    always_comb begin
        alu_ctl   = ALU_ADD;
        flag_w    = 2'b00;
        alu_known = 1'b0;
        if (aluop_c) begin
            case (Funct[4:1])
                4'b0100: begin alu_ctl = ALU_ADD; alu_known = 1'b1; end
                4'b0010: begin alu_ctl = ALU_SUB; alu_known = 1'b1; end
                4'b0000: begin alu_ctl = ALU_AND; alu_known = 1'b1; end
                4'b1100: begin alu_ctl = ALU_ORR; alu_known = 1'b1; end
                default: begin alu_ctl = ALU_ADD; alu_known = 1'b0; end
            endcase
            if (alu_known) begin
                // S bit updates NZ always, CV only for arithmetic ops.
                flag_w[1] = Funct[0];
                flag_w[0] = Funct[0] & ((alu_ctl == ALU_ADD) | (alu_ctl == ALU_SUB));
            end
        end
    end

    // PC logic and output wiring; the immediate/register selects depend only on Op.
    assign PCS        = (regw_c & (Rd == 4'hF)) | branch_c;
    assign NextPC     = nextpc_c;
    assign RegW       = regw_c;
    assign MemW       = memw_c;
    assign FlagW      = flag_w;
    assign IRWrite    = irwrite_c;
    assign AdrSrc     = adrsrc_c;
    assign ResultSrc  = resultsrc_c;
    assign ALUSrcA    = alusrca_c;
    assign ALUSrcB    = alusrcb_c;
    assign ALUControl = alu_ctl;
    assign ImmSrc     = Op;
    assign RegSrc     = {(Op == 2'b01), (Op == 2'b10)};
    assign InstrDone  = done_c;
    assign State      = state_q;

endmodule

// File: tb/tb_arm_mc_decoder.sv
// Bench for arm_mc_decoder: directed and random instructions against a per-instruction step model.
// Latency: one comparison per clock, sampled one time unit after the falling edge.
// Backpressure: none; the bench follows the FSM cycle by cycle.
module tb_arm_mc_decoder;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA, InstrDone;
    logic [1:0] FlagW, ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0] State;

    arm_mc_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .PCS        (PCS),
        .NextPC     (NextPC),
        .RegW       (RegW),
        .MemW       (MemW),
        .FlagW      (FlagW),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .InstrDone  (InstrDone),
        .State      (State)
    );

    typedef struct packed {
        logic       pcs;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic [1:0] flagw;
        logic       irwrite;
        logic       adrsrc;
        logic [1:0] resultsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluctl;
        logic [1:0] immsrc;
        logic [1:0] regsrc;
        logic       done;
        logic [3:0] st;
    } ctl_t;

    int   vectors     = 0;
    int   miscompares = 0;
    ctl_t expq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Everything off; only the Op-derived selects are present.
    function automatic ctl_t idle(input logic [1:0] op, input logic [3:0] st);
        ctl_t c;
        c        = '0;
        c.immsrc = op;
        c.regsrc = {op == 2'b01, op == 2'b10};
        c.st     = st;
        return c;
    endfunction

    // PC+4 datapath selects (used by fetch, decode and while in reset).
    function automatic ctl_t pc_plus4(input logic [1:0] op, input logic [3:0] st);
        ctl_t c;
        c           = idle(op, st);
        c.alusrca   = 1'b1;
        c.alusrcb   = 2'd2;
        c.resultsrc = 2'd2;
        return c;
    endfunction

    // Data-processing semantics: ADD/SUB/AND/ORR, S bit sets NZ, CV only for ADD/SUB.
    function automatic logic [3:0] dp_model(input logic [5:0] fn);
        logic [1:0] op;
        logic       arith;
        if      (fn[4:1] == 4'd4)  begin op = 2'd0; arith = 1'b1; end
        else if (fn[4:1] == 4'd2)  begin op = 2'd1; arith = 1'b1; end
        else if (fn[4:1] == 4'd0)  begin op = 2'd2; arith = 1'b0; end
        else if (fn[4:1] == 4'd12) begin op = 2'd3; arith = 1'b0; end
        else return 4'd0;
        return {op, fn[0], fn[0] & arith};
    endfunction

    // Expected cycle-by-cycle controls for one whole instruction.
    function automatic void build(input logic [1:0] op, input logic [5:0] fn,
                                  input logic [3:0] rd, input int n_unknown);
        ctl_t c;
        expq.delete();
        c = pc_plus4(op, 4'd0); c.irwrite = 1'b1; c.nextpc = 1'b1; expq.push_back(c);
        expq.push_back(pc_plus4(op, 4'd1));
        if (op == 2'b01) begin
            c = idle(op, 4'd2); c.alusrcb = 2'd1; expq.push_back(c);
            if (fn[0]) begin
                c = idle(op, 4'd3); c.adrsrc = 1'b1; expq.push_back(c);
                c = idle(op, 4'd4); c.resultsrc = 2'd1; c.regw = 1'b1;
                c.pcs = (rd == 4'd15); c.done = 1'b1; expq.push_back(c);
            end else begin
                c = idle(op, 4'd5); c.adrsrc = 1'b1; c.memw = 1'b1; c.done = 1'b1;
                expq.push_back(c);
            end
        end else if (op == 2'b00) begin
            c = idle(op, fn[5] ? 4'd7 : 4'd6);
            c.alusrcb = fn[5] ? 2'd1 : 2'd0;
            {c.aluctl, c.flagw} = dp_model(fn);
            expq.push_back(c);
            c = idle(op, 4'd8); c.regw = 1'b1; c.pcs = (rd == 4'd15); c.done = 1'b1;
            expq.push_back(c);
        end else if (op == 2'b10) begin
            c = idle(op, 4'd9); c.alusrcb = 2'd1; c.resultsrc = 2'd2;
            c.pcs = 1'b1; c.done = 1'b1; expq.push_back(c);
        end else begin
            for (int i = 0; i < n_unknown; i++) expq.push_back(idle(op, 4'd10));
        end
    endfunction

    task automatic check(input ctl_t e, input string tag);
        ctl_t o;
        o = {PCS, NextPC, RegW, MemW, FlagW, IRWrite, AdrSrc, ResultSrc, ALUSrcA,
             ALUSrcB, ALUControl, ImmSrc, RegSrc, InstrDone, State};
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Entered just after a falling edge with the DUT in FETCH; leaves at the next such point.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn,
                             input logic [3:0] rd, input int n_unknown, input string tag);
        Op = op; Funct = fn; Rd = rd;
        build(op, fn, rd, n_unknown);
        for (int i = 0; i < expq.size(); i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check(expq[i], $sformatf("%s[%0d]", tag, i));
        end
        @(negedge clk);
    endtask

    logic [1:0] r_op;
    logic [5:0] r_fn;
    logic [3:0] r_rd;
    logic [3:0] cmd_tab [4];

    initial begin
        cmd_tab = '{4'b0100, 4'b0010, 4'b0000, 4'b1100};
        reset = 1'b1; Op = 2'b01; Funct = 6'b0; Rd = 4'd0;

        // Reset held for two cycles with Op=01: enables off, PC+4 selects.
        @(negedge clk); #1; check(pc_plus4(2'b01, 4'd0), "reset_c1");
        @(negedge clk); #1; check(pc_plus4(2'b01, 4'd0), "reset_c2");
        reset = 1'b0;

        // Directed instructions.
        run_instr(2'b01, 6'b011001, 4'd3,  0, "ldr_r3");
        run_instr(2'b01, 6'b011000, 4'd4,  0, "str");
        run_instr(2'b00, 6'b001001, 4'd2,  0, "adds_reg");
        run_instr(2'b00, 6'b111001, 4'd6,  0, "orrs_imm");
        run_instr(2'b10, 6'b100000, 4'd0,  0, "branch");
        run_instr(2'b00, 6'b000100, 4'd15, 0, "sub_r15");
        run_instr(2'b00, 6'b011111, 4'd5,  0, "bad_aluop");
        run_instr(2'b00, 6'b100101, 4'd1,  0, "subs_imm");
        run_instr(2'b01, 6'b011001, 4'd15, 0, "ldr_r15");

        // Random legal instructions.
        for (int k = 0; k < 60; k++) begin
            r_op = 2'($urandom_range(0, 2));
            r_fn = 6'($urandom);
            r_rd = 4'($urandom);
            if ($urandom_range(0, 3) == 0) r_rd = 4'hF;
            if (r_op == 2'b00 && $urandom_range(0, 3) != 0) r_fn[4:1] = cmd_tab[$urandom_range(0, 3)];
            run_instr(r_op, r_fn, r_rd, 0, $sformatf("rnd%0d", k));
        end

        // Reset asserted while in MEMRD: abandon, no register write.
        Op = 2'b01; Funct = 6'b011001; Rd = 4'd7;
        build(2'b01, 6'b011001, 4'd7, 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check(expq[i], $sformatf("ldr_abort[%0d]", i));
        end
        reset = 1'b1;
        #1; check(pc_plus4(2'b01, 4'd3), "reset_in_memrd");
        @(negedge clk); #1; check(pc_plus4(2'b01, 4'd0), "reset_after_memrd");
        reset = 1'b0;
        run_instr(2'b00, 6'b001001, 4'd9, 0, "after_abort");

        // Undefined Op: sticky UNKNOWN, everything off, until reset.
        run_instr(2'b11, 6'b000000, 4'd0, 6, "unknown");
        #1; check(idle(2'b11, 4'd10), "unknown_sticky");
        reset = 1'b1;
        #1; check(pc_plus4(2'b11, 4'd10), "reset_in_unknown");
        @(negedge clk); #1; check(pc_plus4(2'b11, 4'd0), "reset_from_unknown");
        reset = 1'b0;
        run_instr(2'b10, 6'b000000, 4'd0, 0, "branch_after_unknown");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arm_mc_decoder.md
Name: arm_mc_decoder

Overview:
- Multicycle control unit for the ARM datapath. A Moore FSM steps each instruction through fetch, decode, execute and writeback.
- Combinational main, ALU and PC-logic decoders produce the unconditioned controls (PCS, RegW, MemW, FlagW) plus all datapath mux selects and enables.
- Sits upstream of the condition-check/gating logic: that logic ANDs PCS/RegW/MemW/FlagW with CondEx. This block never sees flags or Cond.

Parameters:
- none (ARM subset fixed: LDR/STR imm, ADD/SUB/AND/ORR reg/imm with optional S, B).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- Op  in  2  Instr[27:26] from instruction register
- Funct  in  6  Instr[25:20]
- Rd  in  4  Instr[15:12]
- PCS  out  1  PC written from Result (branch or Rd==15 writeback), unconditioned
- NextPC  out  1  PC+4 update enable (fetch)
- RegW  out  1  register-file write, unconditioned
- MemW  out  1  data memory write, unconditioned
- FlagW  out  2  [1]=NZ write, [0]=CV write, unconditioned
- IRWrite  out  1  instruction register load
- AdrSrc  out  1  0=PC, 1=ALU result as memory address
- ResultSrc  out  2  00=ALUOut reg, 01=Data reg, 10=ALU result direct
- ALUSrcA  out  1  0=RD1, 1=PC
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=constant 4
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)
- InstrDone  out  1  one-cycle pulse in the final state of each instruction
- State  out  4  current state encoding (debug)

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, UNKNOWN=10. State register updates on the clk rising edge.
- Reset: synchronous. State<=FETCH next edge; reset mid-instruction abandons the instruction.
- While reset is high, force to 0: PCS, NextPC, RegW, MemW, FlagW, IRWrite, InstrDone. Selects take their FETCH values.
- Transitions:
  - FETCH->DECODE.
  - DECODE, Op=01 -> MEMADR.
  - DECODE, Op=00 -> EXECR if Funct[5]=0, EXECI if Funct[5]=1.
  - DECODE, Op=10 -> BRANCH.
  - DECODE, Op=11 -> UNKNOWN.
  - MEMADR -> MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD->MEMWB->FETCH. MEMWR->FETCH.
  - EXECR/EXECI->ALUWB->FETCH. BRANCH->FETCH.
  - UNKNOWN is sticky until reset; all enables 0.
- Latencies: LDR 5 cycles, STR 4, data-processing 4, B 3.
- Moore outputs (unlisted enables 0, unlisted selects 0):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1, ALUOp=0.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1, InstrDone=1.
  - MEMWR: AdrSrc=1, MemW=1, InstrDone=1.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1, InstrDone=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1, ALUOp=0, InstrDone=1.
- ALU decoder:
  - ALUOp=0: ALUControl=00, FlagW=00.
  - ALUOp=1, by Funct[4:1]: 0100->00, 0010->01, 0000->10, 1100->11; any other value -> ALUControl=00, FlagW=00.
  - ALUOp=1, decoded op: FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & (ALUControl is 00 or 01).
  - FlagW is asserted only in EXECR/EXECI.
- PCS = (RegW & Rd==4'hF) | Branch. Asserted in ALUWB/MEMWB when Rd=15, and in BRANCH.
- Op/Funct/Rd are held stable by the IR from DECODE onward. The FSM samples Op/Funct only in DECODE and MEMADR.

Test Plan:
- Reset held 2 cycles with Op=01 -> all enables 0 during reset; cycle after release State=0, IRWrite=1, NextPC=1. Reset asserted while in MEMRD -> State=0 next edge, no RegW pulse.
- LDR (Op=01, Funct=011001, Rd=3) -> State 0,1,2,3,4,0. MEMADR: ALUSrcB=01. MEMRD: AdrSrc=1. MEMWB: ResultSrc=01, RegW=1, PCS=0, InstrDone=1.
- STR (Op=01, Funct=011000) -> State 0,1,2,5,0. MEMWR: MemW=1, AdrSrc=1, RegW=0.
- ADDS reg (Op=00, Funct=001001, Rd=2) -> EXECR: ALUControl=00, FlagW=11, ALUSrcB=00. ALUWB: RegW=1. ORRS imm (Funct=111001) -> EXECI: ALUControl=11, FlagW=10.
- B (Op=10) -> State 0,1,9,0. BRANCH: PCS=1, ALUSrcB=01, ResultSrc=10. SUB into R15 (Funct=000100, Rd=15) -> ALUWB: RegW=1, PCS=1, FlagW=00.
- Op=11 -> State 10 held 5+ cycles with every enable 0. Funct[4:1]=1111 with ALUOp=1 -> ALUControl=00, FlagW=00.
